// File: rtl/ctrl_pkg.sv
// Shared constants for the RV32I control decode pipe.
//   - opcode localparams for the RV32I base set
//   - alu_ctrl / branch_ctrl / inst_type encodings
//   - ctrl_t: the non-address part of a decoded bundle
//   - ra_w(): register-address width for a given register count
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b010;
  localparam logic [2:0] BR_BGE  = 3'b011;
  localparam logic [2:0] BR_BLTU = 3'b100;
  localparam logic [2:0] BR_BGEU = 3'b101;

  localparam logic [2:0] IT_R   = 3'b000;
  localparam logic [2:0] IT_U   = 3'b001;
  localparam logic [2:0] IT_J   = 3'b010;
  localparam logic [2:0] IT_I   = 3'b011;
  localparam logic [2:0] IT_S   = 3'b100;
  localparam logic [2:0] IT_B   = 3'b101;
  localparam logic [2:0] IT_ILL = 3'b111;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       shamt_en;
    logic [2:0] branch_ctrl;
    logic       reg_write;
    logic [2:0] inst_type;
    logic       illegal;
  } ctrl_t;

  function automatic int ra_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational RV32I decode and immediate generation.
//   instruction_word : raw 32-bit instruction
//   ctrl             : alu/branch/type/illegal/reg_write controls
//   rd, rs1, rs2     : register addresses (0 where the format has none)
//   imm              : sign-extended immediate (0 for R and illegal)
//   rs1_used/rs2_used: operand actually read, for hazard checking
module ctrl_decode_comb import ctrl_pkg::*; #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [31:0]     instruction_word,
  output ctrl_t           ctrl,
  output logic [RA_W-1:0] rd,
  output logic [RA_W-1:0] rs1,
  output logic [RA_W-1:0] rs2,
  output logic [XLEN-1:0] imm,
  output logic            rs1_used,
  output logic            rs2_used
);

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            has_rd, ill;

  assign opc = instruction_word[6:0];
  assign f3  = instruction_word[14:12];
  assign f7  = instruction_word[31:25];

  assign imm_i = {{(XLEN-12){instruction_word[31]}}, instruction_word[31:20]};
  assign imm_s = {{(XLEN-12){instruction_word[31]}}, instruction_word[31:25],
                  instruction_word[11:7]};
  assign imm_b = {{(XLEN-13){instruction_word[31]}}, instruction_word[31],
                  instruction_word[7], instruction_word[30:25],
                  instruction_word[11:8], 1'b0};
  assign imm_u = {instruction_word[31:12], {(XLEN-20){1'b0}}};
  assign imm_j = {{(XLEN-21){instruction_word[31]}}, instruction_word[31],
                  instruction_word[19:12], instruction_word[20],
                  instruction_word[30:21], 1'b0};

  always_comb begin
    ctrl     = '0;
    imm      = '0;
    has_rd   = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    ill      = 1'b0;
    case (opc)
      OP_R: begin
        ctrl.inst_type = IT_R;
        has_rd   = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        if (f7 == 7'h00) begin
          case (f3)
            3'b000:  ctrl.alu_ctrl = ALU_ADD;
            3'b001:  ctrl.alu_ctrl = ALU_SLL;
            3'b010:  ctrl.alu_ctrl = ALU_SLT;
            3'b011:  ctrl.alu_ctrl = ALU_SLTU;
            3'b100:  ctrl.alu_ctrl = ALU_XOR;
            3'b101:  ctrl.alu_ctrl = ALU_SRL;
            3'b110:  ctrl.alu_ctrl = ALU_OR;
            default: ctrl.alu_ctrl = ALU_AND;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'b000) ctrl.alu_ctrl = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'b101)   ctrl.alu_ctrl = ALU_SRA;
        else ill = 1'b1;
      end
      OP_IMM: begin
        ctrl.inst_type = IT_I;
        has_rd   = 1'b1;
        rs1_used = 1'b1;
        imm      = imm_i;
        case (f3)
          3'b000: ctrl.alu_ctrl = ALU_ADD;
          3'b010: ctrl.alu_ctrl = ALU_SLT;
          3'b011: ctrl.alu_ctrl = ALU_SLTU;
          3'b100: ctrl.alu_ctrl = ALU_XOR;
          3'b110: ctrl.alu_ctrl = ALU_OR;
          3'b111: ctrl.alu_ctrl = ALU_AND;
          3'b001: begin
            ctrl.alu_ctrl = ALU_SLL;
            ctrl.shamt_en = 1'b1;
            ill = (f7 != 7'h00);
          end
          default: begin
            ctrl.shamt_en = 1'b1;
            if (f7 == 7'h00)      ctrl.alu_ctrl = ALU_SRL;
            else if (f7 == 7'h20) ctrl.alu_ctrl = ALU_SRA;
            else                  ill = 1'b1;
          end
        endcase
      end
      // Load/store width lives in funct3 and is the LSU's concern.
      OP_LOAD: begin
        ctrl.inst_type = IT_I;
        ctrl.alu_ctrl  = ALU_ADD;
        has_rd   = 1'b1;
        rs1_used = 1'b1;
        imm      = imm_i;
      end
      OP_STORE: begin
        ctrl.inst_type = IT_S;
        ctrl.alu_ctrl  = ALU_ADD;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm      = imm_s;
      end
      OP_BRANCH: begin
        ctrl.inst_type = IT_B;
        ctrl.alu_ctrl  = ALU_SUB;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm      = imm_b;
        case (f3)
          3'b000:  ctrl.branch_ctrl = BR_BEQ;
          3'b001:  ctrl.branch_ctrl = BR_BNE;
          3'b100:  ctrl.branch_ctrl = BR_BLT;
          3'b101:  ctrl.branch_ctrl = BR_BGE;
          3'b110:  ctrl.branch_ctrl = BR_BLTU;
          3'b111:  ctrl.branch_ctrl = BR_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OP_LUI, OP_AUIPC: begin
        ctrl.inst_type = IT_U;
        ctrl.alu_ctrl  = ALU_ADD;
        has_rd = 1'b1;
        imm    = imm_u;
      end
      OP_JAL: begin
        ctrl.inst_type = IT_J;
        ctrl.alu_ctrl  = ALU_ADD;
        has_rd = 1'b1;
        imm    = imm_j;
      end
      OP_JALR: begin
        ctrl.inst_type = IT_I;
        ctrl.alu_ctrl  = ALU_ADD;
        has_rd   = 1'b1;
        rs1_used = 1'b1;
        imm      = imm_i;
      end
      default: ill = 1'b1;
    endcase
    // Illegal collapses to a clean all-zero bundle with only the flag/type set.
    if (ill) begin
      ctrl           = '0;
      ctrl.illegal   = 1'b1;
      ctrl.inst_type = IT_ILL;
      imm            = '0;
      has_rd         = 1'b0;
      rs1_used       = 1'b0;
      rs2_used       = 1'b0;
    end
    ctrl.reg_write = has_rd && (instruction_word[11:7] != 5'd0);
  end

  assign rd  = has_rd   ? RA_W'(instruction_word[11:7])  : '0;
  assign rs1 = rs1_used ? RA_W'(instruction_word[19:15]) : '0;
  assign rs2 = rs2_used ? RA_W'(instruction_word[24:20]) : '0;

endmodule

// File: rtl/control_decode_pipe.sv
// Registered RV32I control decoder with valid/ready handshakes, RAW
// scoreboard and flush. One output register stage, latency 1.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : instruction handshake from fetch
//   instruction_word      : raw instruction
//   out_valid/out_ready   : decoded-bundle handshake to regfile/ALU
//   alu_ctrl .. imm       : registered decoded bundle
//   wb_valid, wb_rd       : writeback retiring rd (releases pending)
//   flush                 : kill the bundle held in the output stage
module control_decode_pipe import ctrl_pkg::*; #(
  parameter int XLEN          = 32,
  parameter int NUM_REGS      = 32,
  parameter bit SCOREBOARD_EN = 1'b1,
  parameter int RA_W          = ra_w(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_ctrl,
  output logic            shamt_en,
  output logic [2:0]      branch_ctrl,
  output logic            reg_write,
  output logic [2:0]      inst_type,
  output logic            illegal,
  output logic [RA_W-1:0] rd,
  output logic [RA_W-1:0] rs1,
  output logic [RA_W-1:0] rs2,
  output logic [XLEN-1:0] imm,
  input  logic            wb_valid,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            flush
);

  ctrl_t               dec_ctrl, out_ctrl;
  logic [RA_W-1:0]     dec_rd, dec_rs1, dec_rs2;
  logic [XLEN-1:0]     dec_imm;
  logic                dec_rs1_used, dec_rs2_used;
  logic [NUM_REGS-1:0] pending, pend_wb, pending_nxt;
  logic [NUM_REGS-1:0] wb_clr, fl_clr, acc_set;
  logic                hazard, accept;

  ctrl_decode_comb #(.XLEN(XLEN), .RA_W(RA_W)) u_dec (
    .instruction_word (instruction_word),
    .ctrl             (dec_ctrl),
    .rd               (dec_rd),
    .rs1              (dec_rs1),
    .rs2              (dec_rs2),
    .imm              (dec_imm),
    .rs1_used         (dec_rs1_used),
    .rs2_used         (dec_rs2_used)
  );

  always_comb begin
    wb_clr  = '0;
    fl_clr  = '0;
    acc_set = '0;
    if (wb_valid) wb_clr[wb_rd] = 1'b1;
    if (flush && out_valid && out_ctrl.reg_write) fl_clr[rd] = 1'b1;
    if (accept && dec_ctrl.reg_write) acc_set[dec_rd] = 1'b1;
  end

  // Hazard sees this cycle's writeback already applied so a retiring
  // register releases the stalled consumer in the same cycle.
  assign pend_wb  = pending & ~wb_clr;
  assign hazard   = SCOREBOARD_EN &&
                    ((dec_rs1_used && pend_wb[dec_rs1]) ||
                     (dec_rs2_used && pend_wb[dec_rs2]));
  assign in_ready = ~flush & ~hazard & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // A new allocation beats a same-cycle clear; x0 can never be pending.
  assign pending_nxt = ((pending & ~wb_clr & ~fl_clr) | acc_set) &
                       {{(NUM_REGS-1){1'b1}}, 1'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      imm       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_ctrl  <= dec_ctrl;
      rd        <= dec_rd;
      rs1       <= dec_rs1;
      rs2       <= dec_rs2;
      imm       <= dec_imm;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign alu_ctrl    = out_ctrl.alu_ctrl;
  assign shamt_en    = out_ctrl.shamt_en;
  assign branch_ctrl = out_ctrl.branch_ctrl;
  assign reg_write   = out_ctrl.reg_write;
  assign inst_type   = out_ctrl.inst_type;
  assign illegal     = out_ctrl.illegal;

endmodule

// File: tb/tb_control_decode_pipe.sv
module tb_control_decode_pipe;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1, wb_valid = 1'b0, flush = 1'b0;
  logic [31:0] instruction_word = '0;
  logic [4:0]  wb_rd = '0;
  logic        in_ready, out_valid, shamt_en, reg_write, illegal;
  logic [3:0]  alu_ctrl;
  logic [2:0]  branch_ctrl, inst_type;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  always #5 clk = ~clk;

  control_decode_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_word(instruction_word), .out_valid(out_valid),
    .out_ready(out_ready), .alu_ctrl(alu_ctrl), .shamt_en(shamt_en),
    .branch_ctrl(branch_ctrl), .reg_write(reg_write), .inst_type(inst_type),
    .illegal(illegal), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] alu; logic sh; logic [2:0] br; logic rw; logic [2:0] ty; logic il;
    logic [4:0] rd, rs1, rs2; logic [31:0] imm; logic u1, u2;
  } exp_t;

  string r_names[8]  = '{"add","sll","slt","sltu","xor","srl","or","and"};
  string i_names[8]  = '{"addi","-","slti","sltiu","xori","-","ori","andi"};
  string b_names[8]  = '{"beq","bne","ill","ill","blt","bge","bltu","bgeu"};
  string br_list[6]  = '{"beq","bne","blt","bge","bltu","bgeu"};
  logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
  logic [3:0] alu_of[string];

  task automatic init_tables();
    alu_of["and"] = 0;  alu_of["andi"] = 0;  alu_of["or"] = 1;   alu_of["ori"] = 1;
    alu_of["add"] = 2;  alu_of["addi"] = 2;  alu_of["load"] = 2; alu_of["store"] = 2;
    alu_of["lui"] = 2;  alu_of["auipc"] = 2; alu_of["jal"] = 2;  alu_of["jalr"] = 2;
    alu_of["sll"] = 3;  alu_of["slli"] = 3;  alu_of["sub"] = 4;  alu_of["srl"] = 5;
    alu_of["srli"] = 5; alu_of["xor"] = 7;   alu_of["xori"] = 7; alu_of["slt"] = 8;
    alu_of["slti"] = 8; alu_of["sra"] = 9;   alu_of["srai"] = 9; alu_of["sltu"] = 10;
    alu_of["sltiu"] = 10;
    for (int k = 0; k < 6; k++) alu_of[br_list[k]] = 4;
  endtask

  function automatic string mnem(input logic [31:0] w);
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    case (w[6:0])
      7'h33: begin
        if (f7 == 7'h00) return r_names[f3];
        if (f7 == 7'h20 && f3 == 3'd0) return "sub";
        if (f7 == 7'h20 && f3 == 3'd5) return "sra";
        return "ill";
      end
      7'h13: begin
        if (f3 == 3'd1) begin if (f7 == 7'h00) return "slli"; return "ill"; end
        if (f3 == 3'd5) begin
          if (f7 == 7'h00) return "srli";
          if (f7 == 7'h20) return "srai";
          return "ill";
        end
        return i_names[f3];
      end
      7'h03: return "load";
      7'h23: return "store";
      7'h63: return b_names[f3];
      7'h37: return "lui";
      7'h17: return "auipc";
      7'h6F: return "jal";
      7'h67: return "jalr";
      default: return "ill";
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] w);
    exp_t e; string m, f; int v;
    e = '0;
    m = mnem(w);
    if (m == "ill") begin e.il = 1'b1; e.ty = 3'b111; return e; end
    if (w[6:0] == 7'h33) f = "R";
    else if (w[6:0] == 7'h23) f = "S";
    else if (w[6:0] == 7'h63) f = "B";
    else if (w[6:0] == 7'h37 || w[6:0] == 7'h17) f = "U";
    else if (w[6:0] == 7'h6F) f = "J";
    else f = "I";
    e.alu = alu_of[m];
    e.sh  = (m == "slli" || m == "srli" || m == "srai");
    for (int k = 0; k < 6; k++) if (br_list[k] == m) e.br = 3'(k);
    v = 0;
    if (f == "R")      begin e.ty = 3'd0; v = 0; end
    else if (f == "U") begin e.ty = 3'd1; v = 4096 * int'(w[31:12]); end
    else if (f == "J") begin
      e.ty = 3'd2;
      v = 2*int'(w[30:21]) + 2048*int'(w[20]) + 4096*int'(w[19:12]) - 1048576*int'(w[31]);
    end
    else if (f == "I") begin e.ty = 3'd3; v = int'(w[30:20]) - 2048*int'(w[31]); end
    else if (f == "S") begin
      e.ty = 3'd4; v = int'(w[11:7]) + 32*int'(w[30:25]) - 2048*int'(w[31]);
    end else begin
      e.ty = 3'd5;
      v = 2*int'(w[11:8]) + 32*int'(w[30:25]) + 2048*int'(w[7]) - 4096*int'(w[31]);
    end
    e.imm = 32'(v);
    e.u1  = (f == "R" || f == "I" || f == "S" || f == "B");
    e.u2  = (f == "R" || f == "S" || f == "B");
    e.rd  = (f == "S" || f == "B") ? 5'd0 : w[11:7];
    e.rs1 = e.u1 ? w[19:15] : 5'd0;
    e.rs2 = e.u2 ? w[24:20] : 5'd0;
    e.rw  = (e.rd != 5'd0);
    return e;
  endfunction

  // model state
  logic        m_ov = 1'b0;
  exp_t        m_out = '0;
  logic [31:0] m_pend = '0;
  logic        obs_rdy;

  task automatic drv(input logic iv, input logic [31:0] w, input logic ordy,
                     input logic wbv, input logic [4:0] wbr, input logic fl);
    in_valid = iv; instruction_word = w; out_ready = ordy;
    wb_valid = wbv; wb_rd = wbr; flush = fl;
  endtask

  // Called at posedge+1 with inputs driven; checks, clocks, advances model.
  task automatic step();
    exp_t d; logic [31:0] pw, np; logic hz, rdy, acc;
    #3;
    d  = model(instruction_word);
    pw = m_pend;
    if (wb_valid) pw[wb_rd] = 1'b0;
    hz  = (d.u1 && pw[d.rs1]) || (d.u2 && pw[d.rs2]);
    rdy = !flush && !hz && (!m_ov || out_ready);
    obs_rdy = in_ready;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov)
      chk("bundle", 64'({alu_ctrl, shamt_en, branch_ctrl, reg_write, inst_type, illegal,
                         rd, rs1, rs2, imm}),
                    64'({m_out.alu, m_out.sh, m_out.br, m_out.rw, m_out.ty, m_out.il,
                         m_out.rd, m_out.rs1, m_out.rs2, m_out.imm}));
    chk("pending", 64'(dut.pending), 64'(m_pend));
    @(posedge clk);
    acc = in_valid && rdy;
    if (!rst_n) begin
      m_ov = 1'b0; m_out = '0; m_pend = '0;
    end else begin
      np = m_pend;
      if (flush && m_ov && m_out.rw) np[m_out.rd] = 1'b0;
      if (wb_valid) np[wb_rd] = 1'b0;
      if (acc && d.rw) np[d.rd] = 1'b1;
      np[0] = 1'b0;
      m_pend = np;
      if (flush) m_ov = 1'b0;
      else if (acc) begin m_ov = 1'b1; m_out = d; end
      else if (out_ready) m_ov = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(0, 32'h0, 1, 0, 0, 0);
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 10);
    w[6:0]   = (k < 9) ? ops[k] : 7'($urandom);
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13)
      case ($urandom_range(0, 3))
        0, 1: w[31:25] = 7'h00;
        2:    w[31:25] = 7'h20;
        default: ;
      endcase
    return w;
  endfunction

  initial begin
    int cnt;
    init_tables();
    // reset
    drv(0, 32'h0, 1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_bundle", 64'({alu_ctrl, shamt_en, branch_ctrl, reg_write, inst_type, illegal,
                           rd, rs1, rs2, imm}), 64'd0);
    chk("rst_pending", 64'(dut.pending), 64'd0);

    // ADD x3,x1,x2
    drv(1, 32'h002081B3, 1, 0, 0, 0); step();
    drv(0, 32'h0, 1, 0, 0, 0);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_alu", 64'(alu_ctrl), 64'b0010);
    chk("add_type", 64'(inst_type), 64'b000);
    chk("add_rd", 64'(rd), 64'd3);
    chk("add_rw", 64'(reg_write), 64'd1);
    chk("add_imm", 64'(imm), 64'd0);
    chk("add_pend3", 64'(dut.pending[3]), 64'd1);
    step();

    // SUB and a bad funct7
    do_reset();
    drv(1, 32'h407302B3, 1, 0, 0, 0); step();
    chk("sub_alu", 64'(alu_ctrl), 64'b0100);
    drv(1, 32'h027302B3, 1, 0, 0, 0); step();
    chk("badf7_ill", 64'(illegal), 64'd1);
    chk("badf7_type", 64'(inst_type), 64'b111);
    chk("badf7_rw", 64'(reg_write), 64'd0);

    // RAW stall released by same-cycle writeback
    do_reset();
    drv(1, 32'h00500093, 1, 0, 0, 0); step();
    drv(1, 32'h002081B3, 1, 0, 0, 0); step();
    chk("raw_stall0", 64'(obs_rdy), 64'd0);
    step();
    chk("raw_stall1", 64'(obs_rdy), 64'd0);
    drv(1, 32'h002081B3, 1, 1, 5'd1, 0); step();
    chk("raw_release", 64'(obs_rdy), 64'd1);
    drv(0, 32'h0, 1, 0, 0, 0);
    chk("raw_out_valid", 64'(out_valid), 64'd1);
    chk("raw_out_rd", 64'(rd), 64'd3);
    step();

    // BEQ x1,x2,+8
    do_reset();
    drv(1, 32'h00208463, 1, 0, 0, 0); step();
    chk("beq_br", 64'(branch_ctrl), 64'b000);
    chk("beq_type", 64'(inst_type), 64'b101);
    chk("beq_imm", 64'(imm), 64'd8);
    chk("beq_rw", 64'(reg_write), 64'd0);
    chk("beq_pend", 64'(dut.pending), 64'd0);

    // LUI held under backpressure, then flushed
    do_reset();
    drv(1, 32'h123450B7, 0, 0, 0, 0); step();
    drv(1, 32'h00500113, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("lui_hold_rdy", 64'(obs_rdy), 64'd0);
      chk("lui_hold_imm", 64'(imm), 64'h12345000);
      chk("lui_hold_valid", 64'(out_valid), 64'd1);
    end
    drv(0, 32'h0, 0, 0, 0, 1); step();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_pend1", 64'(dut.pending[1]), 64'd0);
    drv(0, 32'h0, 1, 0, 0, 0); step();

    // 8 independent instructions back to back, then reset mid-stream
    do_reset();
    cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      drv(1, (32'(k) << 20) | (32'(k) << 7) | 32'h13, 1, 0, 0, 0);
      step();
      if (out_valid) cnt++;
    end
    chk("stream_cnt", 64'(cnt), 64'd8);
    rst_n = 1'b0;
    drv(1, 32'h00900493, 1, 0, 0, 0); step();
    rst_n = 1'b1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_pend", 64'(dut.pending), 64'd0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      drv($urandom_range(0, 3) != 0, rnd_inst(), $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
          $urandom_range(0, 19) == 0);
      step();
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
